// File: rtl/intr_pkg.sv
// ---------------------------------------------------------------------------
// intr_pkg
// Shared definitions for the interrupt controller slice:
//   - N_CH_MIN / N_CH_MAX / N_CH_DEFAULT : legal bounds and default channel count
//   - intr_state_e                       : request FSM states (IDLE, REQ, SERVICE)
// ---------------------------------------------------------------------------
package intr_pkg;

    localparam int N_CH_MIN     = 2;
    localparam int N_CH_MAX     = 16;
    localparam int N_CH_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        SERVICE = 2'd2
    } intr_state_e;

endpackage

// File: rtl/intr_ctrl_if.sv
// ---------------------------------------------------------------------------
// intr_ctrl_if
// Bundles the CPU/peripheral-facing signals of intr_ctrl.
//   master : the side that raises interrupts and programs the controller
//            (drives irq_in, mode, mask/clear writes, int_ack, eoi)
//   slave  : the controller itself (drives interrupt, int_id, pending, mask)
// ---------------------------------------------------------------------------
interface intr_ctrl_if
    import intr_pkg::*;
#(
    parameter int N_CH = N_CH_DEFAULT
);
    localparam int ID_W = $clog2(N_CH);

    logic [N_CH-1:0] irq_in;
    logic [N_CH-1:0] mode;
    logic            mask_wr;
    logic [N_CH-1:0] mask_data;
    logic            clr_wr;
    logic [N_CH-1:0] clr_data;
    logic            int_ack;
    logic            eoi;
    logic            interrupt;
    logic [ID_W-1:0] int_id;
    logic [N_CH-1:0] pending;
    logic [N_CH-1:0] mask;

    modport master (
        output irq_in, mode, mask_wr, mask_data, clr_wr, clr_data, int_ack, eoi,
        input  interrupt, int_id, pending, mask
    );

    modport slave (
        input  irq_in, mode, mask_wr, mask_data, clr_wr, clr_data, int_ack, eoi,
        output interrupt, int_id, pending, mask
    );

endinterface

// File: rtl/intr_prio_enc.sv
// ---------------------------------------------------------------------------
// intr_prio_enc
// Fixed-priority encoder: the lowest set bit of req wins.
//   req   in  N     request vector
//   valid out 1     at least one request bit is set
//   id    out ID_W  index of the lowest set bit (0 when valid = 0)
// ---------------------------------------------------------------------------
module intr_prio_enc #(
    parameter int N    = 8,
    parameter int ID_W = $clog2(N)
) (
    input  logic [N-1:0]    req,
    output logic            valid,
    output logic [ID_W-1:0] id
);

    // Scan from the top down so the last (lowest) hit overwrites earlier ones.
    always_comb begin
        valid = 1'b0;
        id    = '0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[i]) begin
                valid = 1'b1;
                id    = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/intr_ctrl.sv
// ---------------------------------------------------------------------------
// intr_ctrl
// Multi-channel interrupt controller with per-channel edge/level triggering,
// pending latches, an enable mask and a single-level request/ack/eoi handshake.
//   clk       in  1     sole clock, rising edge
//   rst_sync  in  1     synchronous active-high reset
//   bus       slave modport of intr_ctrl_if:
//     irq_in, mode, mask_wr/mask_data, clr_wr/clr_data, int_ack, eoi  (inputs)
//     interrupt, int_id, pending, mask                                (outputs)
// ---------------------------------------------------------------------------
module intr_ctrl
    import intr_pkg::*;
#(
    parameter int N_CH = N_CH_DEFAULT
) (
    input  logic      clk,
    input  logic      rst_sync,
    intr_ctrl_if.slave bus
);

    localparam int ID_W = $clog2(N_CH);

    logic [N_CH-1:0] irq_prev;
    logic [N_CH-1:0] pending_q;
    logic [N_CH-1:0] mask_q;
    logic [N_CH-1:0] trigger;
    logic [N_CH-1:0] clr_vec;
    logic [N_CH-1:0] req_vec;
    logic [ID_W-1:0] int_id_q;
    logic [ID_W-1:0] int_id_next;
    logic [ID_W-1:0] win_id;
    logic            win_valid;
    logic            interrupt_q;
    logic            interrupt_next;
    logic            ack_take;
    intr_state_e     state_q;
    intr_state_e     state_next;

    // irq_prev follows irq_in even during reset, so a line that is already
    // high when reset releases is not mistaken for a rising edge.
    always_ff @(posedge clk) begin
        irq_prev <= bus.irq_in;
    end

    // Edge channels fire on a 0->1 transition, level channels whenever high.
    assign trigger = (bus.irq_in & ~bus.mode) | (bus.irq_in & ~irq_prev & bus.mode);

    // An ack only counts while a request is outstanding; it then clears the
    // pending bit of the channel being acknowledged.
    assign ack_take = (state_q == REQ) && bus.int_ack;
    assign clr_vec  = (bus.clr_wr ? bus.clr_data : '0)
                    | (ack_take ? (N_CH'(1) << int_id_q) : '0);

    // Pending latches ignore the mask, and a set beats a same-cycle clear so
    // no event is ever dropped (this also re-pends a level line held through ack).
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            pending_q <= '0;
        end else begin
            pending_q <= trigger | (pending_q & ~clr_vec);
        end
    end

    // Enable register, loaded whole on a mask write strobe.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            mask_q <= '0;
        end else if (bus.mask_wr) begin
            mask_q <= bus.mask_data;
        end
    end

    assign req_vec = pending_q & mask_q;

    intr_prio_enc #(
        .N    (N_CH),
        .ID_W (ID_W)
    ) u_prio_enc (
        .req   (req_vec),
        .valid (win_valid),
        .id    (win_id)
    );

    // Request FSM registers; reset aborts any request or service in progress.
    always_ff @(posedge clk) begin
        if (rst_sync) begin
            state_q     <= IDLE;
            int_id_q    <= '0;
            interrupt_q <= 1'b0;
        end else begin
            state_q     <= state_next;
            int_id_q    <= int_id_next;
            interrupt_q <= interrupt_next;
        end
    end

    // Next-state logic. int_id is only reloaded when leaving IDLE, so it stays
    // frozen through REQ and SERVICE. In REQ an ack takes precedence over a
    // retraction caused by the request's pending or mask bit going away.
    always_comb begin
        state_next     = state_q;
        int_id_next    = int_id_q;
        interrupt_next = interrupt_q;
        case (state_q)
            IDLE: begin
                interrupt_next = 1'b0;
                if (win_valid) begin
                    state_next     = REQ;
                    int_id_next    = win_id;
                    interrupt_next = 1'b1;
                end
            end
            REQ: begin
                if (bus.int_ack) begin
                    state_next     = SERVICE;
                    interrupt_next = 1'b0;
                end else if (!req_vec[int_id_q]) begin
                    state_next     = IDLE;
                    interrupt_next = 1'b0;
                end
            end
            SERVICE: begin
                interrupt_next = 1'b0;
                if (bus.eoi) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next     = IDLE;
                interrupt_next = 1'b0;
            end
        endcase
    end

    assign bus.interrupt = interrupt_q;
    assign bus.int_id    = int_id_q;
    assign bus.pending   = pending_q;
    assign bus.mask      = mask_q;

endmodule

// File: tb/tb_intr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_intr_ctrl
// Self-checking bench for intr_ctrl at N_CH = 8: directed scenarios followed
// by randomized traffic, all compared against a behavioural reference model.
// ---------------------------------------------------------------------------
module tb_intr_ctrl;

    localparam int N = 8;

    localparam int PH_IDLE     = 0;
    localparam int PH_WAIT_ACK = 1;
    localparam int PH_HANDLER  = 2;

    logic clk = 1'b0;
    logic rst_sync;

    always #5 clk = ~clk;

    intr_ctrl_if #(.N_CH(N)) bus();

    intr_ctrl #(.N_CH(N)) dut (
        .clk      (clk),
        .rst_sync (rst_sync),
        .bus      (bus.slave)
    );

    int test_count = 0;
    int fail_count = 0;

    // Reference model state: one bit per pending channel, the enable word,
    // the previous irq sample, the requested channel and the handshake phase.
    bit         m_pend[N];
    bit [N-1:0] m_mask;
    bit [N-1:0] m_prev;
    int         m_id;
    bit         m_intr;
    int         m_phase;

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        test_count++;
        if (obs !== exp) begin
            fail_count++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] modelPending();
        logic [31:0] v;
        v = '0;
        for (int i = 0; i < N; i++) v[i] = m_pend[i];
        return v;
    endfunction

    // Advances the model by one clock using the inputs present at the edge.
    task automatic modelStep();
        bit new_p[N];
        bit ack_hit;
        bit rise;
        bit cleared;
        int first;
        if (rst_sync) begin
            for (int i = 0; i < N; i++) m_pend[i] = 1'b0;
            m_mask  = '0;
            m_id    = 0;
            m_intr  = 1'b0;
            m_phase = PH_IDLE;
            m_prev  = bus.irq_in;
            return;
        end
        ack_hit = (m_phase == PH_WAIT_ACK) && bus.int_ack;
        for (int i = 0; i < N; i++) begin
            rise    = bus.mode[i] ? (bus.irq_in[i] && !m_prev[i]) : bus.irq_in[i];
            cleared = (bus.clr_wr && bus.clr_data[i]) || (ack_hit && i == m_id);
            new_p[i] = rise || (m_pend[i] && !cleared);
        end
        case (m_phase)
            PH_IDLE: begin
                first = -1;
                for (int i = 0; i < N; i++)
                    if (first < 0 && m_pend[i] && m_mask[i]) first = i;
                if (first >= 0) begin
                    m_phase = PH_WAIT_ACK;
                    m_id    = first;
                    m_intr  = 1'b1;
                end
            end
            PH_WAIT_ACK: begin
                if (bus.int_ack) begin
                    m_phase = PH_HANDLER;
                    m_intr  = 1'b0;
                end else if (!(m_pend[m_id] && m_mask[m_id])) begin
                    m_phase = PH_IDLE;
                    m_intr  = 1'b0;
                end
            end
            default: begin
                if (bus.eoi) m_phase = PH_IDLE;
            end
        endcase
        for (int i = 0; i < N; i++) m_pend[i] = new_p[i];
        if (bus.mask_wr) m_mask = bus.mask_data;
        m_prev = bus.irq_in;
    endtask

    // One clock: update the model at the edge, compare on the falling edge,
    // then drop the one-cycle strobes.
    task automatic applyStimulus();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkOutput("interrupt", bus.interrupt, m_intr);
        checkOutput("int_id",    bus.int_id,    m_id);
        checkOutput("pending",   bus.pending,   modelPending());
        checkOutput("mask",      bus.mask,      m_mask);
        bus.mask_wr = 1'b0;
        bus.clr_wr  = 1'b0;
        bus.int_ack = 1'b0;
        bus.eoi     = 1'b0;
    endtask

    task automatic writeMask(input logic [N-1:0] value);
        bus.mask_wr   = 1'b1;
        bus.mask_data = value;
        applyStimulus();
    endtask

    initial begin
        rst_sync      = 1'b1;
        bus.irq_in    = '0;
        bus.mode      = 8'hFF;
        bus.mask_wr   = 1'b0;
        bus.mask_data = '0;
        bus.clr_wr    = 1'b0;
        bus.clr_data  = '0;
        bus.int_ack   = 1'b0;
        bus.eoi       = 1'b0;
        m_phase       = PH_IDLE;
        applyStimulus();
        applyStimulus();
        checkOutput("rst_interrupt", bus.interrupt, 0);
        checkOutput("rst_pending",   bus.pending,   0);
        rst_sync = 1'b0;

        // Scenario 1: single edge pulse on channel 3.
        writeMask(8'hFF);
        bus.irq_in = 8'h08;
        applyStimulus();
        checkOutput("s1_pending", bus.pending, 8'h08);
        checkOutput("s1_intr_early", bus.interrupt, 0);
        bus.irq_in = 8'h00;
        applyStimulus();
        checkOutput("s1_interrupt", bus.interrupt, 1);
        checkOutput("s1_int_id", bus.int_id, 3);
        bus.int_ack = 1'b1;
        applyStimulus();
        checkOutput("s1_ack_pending", bus.pending, 8'h00);
        checkOutput("s1_ack_intr", bus.interrupt, 0);
        bus.eoi = 1'b1;
        applyStimulus();
        applyStimulus();

        // Scenario 2: simultaneous edges on channels 2 and 5.
        bus.irq_in = 8'h24;
        applyStimulus();
        bus.irq_in = 8'h00;
        applyStimulus();
        checkOutput("s2_first_id", bus.int_id, 2);
        bus.int_ack = 1'b1;
        applyStimulus();
        bus.eoi = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("s2_second_id", bus.int_id, 5);
        checkOutput("s2_second_intr", bus.interrupt, 1);
        bus.int_ack = 1'b1;
        applyStimulus();
        bus.eoi = 1'b1;
        applyStimulus();

        // Scenario 3: event while masked, then unmask.
        writeMask(8'h00);
        bus.irq_in = 8'h02;
        applyStimulus();
        bus.irq_in = 8'h00;
        applyStimulus();
        applyStimulus();
        checkOutput("s3_pending", bus.pending, 8'h02);
        checkOutput("s3_masked_intr", bus.interrupt, 0);
        writeMask(8'h02);
        checkOutput("s3_intr_not_yet", bus.interrupt, 0);
        applyStimulus();
        checkOutput("s3_intr", bus.interrupt, 1);
        checkOutput("s3_int_id", bus.int_id, 1);
        bus.int_ack = 1'b1;
        applyStimulus();
        bus.eoi = 1'b1;
        applyStimulus();
        writeMask(8'hFF);

        // Scenario 4: level channel 4 held high through ack.
        bus.mode   = 8'hEF;
        bus.irq_in = 8'h10;
        applyStimulus();
        applyStimulus();
        checkOutput("s4_int_id", bus.int_id, 4);
        bus.int_ack = 1'b1;
        applyStimulus();
        checkOutput("s4_repend", bus.pending, 8'h10);
        bus.eoi = 1'b1;
        applyStimulus();
        applyStimulus();
        checkOutput("s4_rereq_intr", bus.interrupt, 1);
        checkOutput("s4_rereq_id", bus.int_id, 4);
        bus.irq_in  = 8'h00;
        bus.int_ack = 1'b1;
        applyStimulus();
        bus.eoi = 1'b1;
        applyStimulus();
        bus.mode = 8'hFF;

        // Scenario 5: clear racing a new edge, then retraction by clear.
        bus.irq_in   = 8'h01;
        bus.clr_wr   = 1'b1;
        bus.clr_data = 8'h01;
        applyStimulus();
        checkOutput("s5_set_wins", bus.pending, 8'h01);
        bus.irq_in = 8'h00;
        applyStimulus();
        checkOutput("s5_int_id", bus.int_id, 0);
        bus.clr_wr   = 1'b1;
        bus.clr_data = 8'h01;
        applyStimulus();
        applyStimulus();
        checkOutput("s5_retract", bus.interrupt, 0);

        // Scenario 6: reset during SERVICE with channel 7 held high.
        bus.irq_in = 8'h80;
        applyStimulus();
        applyStimulus();
        bus.int_ack = 1'b1;
        applyStimulus();
        rst_sync = 1'b1;
        applyStimulus();
        checkOutput("s6_rst_outputs", {bus.interrupt, bus.int_id, bus.pending, bus.mask}, 0);
        rst_sync = 1'b0;
        applyStimulus();
        applyStimulus();
        checkOutput("s6_no_edge", bus.pending, 8'h00);
        writeMask(8'hFF);

        // Randomized traffic; acks and eois are biased towards the model phase
        // where they matter so the full handshake is exercised often.
        for (int cyc = 0; cyc < 1500; cyc++) begin
            bus.irq_in = N'($urandom);
            if ($urandom_range(0, 15) == 0) bus.mode = N'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                bus.mask_wr   = 1'b1;
                bus.mask_data = N'($urandom);
            end
            if ($urandom_range(0, 5) == 0) begin
                bus.clr_wr   = 1'b1;
                bus.clr_data = N'($urandom);
            end
            bus.int_ack = m_intr ? ($urandom_range(0, 1) == 0) : ($urandom_range(0, 9) == 0);
            bus.eoi     = (m_phase == PH_HANDLER) ? ($urandom_range(0, 2) == 0)
                                                  : ($urandom_range(0, 9) == 0);
            rst_sync    = ($urandom_range(0, 59) == 0);
            applyStimulus();
        end

        $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
        $finish;
    end

endmodule
